sync_payload_capture: RTL and testbench

Consumes the serial bit stream and the single-cycle sync-match pulse from the upstream sequence detector. After each sync match it shifts in the next PAYLOAD_W stream bits, MSB first. It presents each completed payload word on a one-entry valid/ready output register. Frame and dropped-frame statistics are kept for the control/status block.

---
 rtl/sync_cap_pkg.sv | 22 ++
 rtl/sync_payload_capture_hold.sv | 44 ++++
 rtl/sync_payload_capture.sv | 108 ++++++++++
 tb/tb_sync_payload_capture.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_cap_pkg.sv
// Shared definitions for the sync payload capture block: FSM state type,
// default widths and the saturating counter increment.
package sync_cap_pkg;

    localparam int DEF_PAYLOAD_W = 8;
    localparam int DEF_CNT_W     = 8;

    typedef enum logic [0:0] {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } cap_state_e;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        if (value >= max_value) begin
            return value;
        end
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/sync_payload_capture_hold.sv
// One-entry output register for captured payload words.
//
// Handshake: a word transfers on every rising edge where out_valid && out_ready.
// out_valid never drops without that transfer, and out_data is frozen while
// out_valid && !out_ready. A load is accepted when the register is empty or
// is being emptied on the same edge; otherwise the load is reported as a drop
// and the held word is kept untouched.
module payload_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         accept,
    output logic         drop
);

    logic pop;

    // Accept/drop decision from the registered valid bit and the consumer's ready.
    always_comb begin
        pop    = out_valid && out_ready;
        accept = load && (!out_valid || out_ready);
        drop   = load && out_valid && !out_ready;
    end

    // Load on accept, otherwise empty the register when the word is consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sync_payload_capture.sv
// Captures PAYLOAD_W stream bits (MSB first) after each sync-match pulse and
// hands the word to a one-entry valid/ready register. Keeps saturating frame
// and drop counts plus a sticky overflow flag for the status block.
module sync_payload_capture
    import sync_cap_pkg::*;
#(
    parameter int PAYLOAD_W = DEF_PAYLOAD_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 din,
    input  logic                 det,
    input  logic                 clr,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic                 ovf
);

    localparam int IDX_W = (PAYLOAD_W > 1) ? $clog2(PAYLOAD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_W - 1);
    localparam logic [31:0] CNT_MAX =
        (CNT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);

    cap_state_e           state;
    logic [IDX_W-1:0]     bit_idx;
    logic [PAYLOAD_W-1:0] shift_reg;
    logic [PAYLOAD_W-1:0] next_word;
    logic                 last_bit;
    logic                 accept;
    logic                 drop;

    assign next_word = {shift_reg[PAYLOAD_W-2:0], din};
    assign last_bit  = (state == SHIFT) && (bit_idx == LAST_IDX);
    // busy is the registered state bit itself, so it doubles as the FSM view.
    assign busy      = (state == SHIFT);

    // Hunt for a sync pulse, then shift in exactly PAYLOAD_W bits; det is ignored while shifting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                HUNT: begin
                    if (det) begin
                        state   <= SHIFT;
                        bit_idx <= '0;
                    end
                end
                SHIFT: begin
                    shift_reg <= next_word;
                    if (last_bit) begin
                        state   <= HUNT;
                        bit_idx <= '0;
                    end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                    end
                end
                default: begin
                    state   <= HUNT;
                    bit_idx <= '0;
                end
            endcase
        end
    end

    payload_hold_reg #(
        .W (PAYLOAD_W)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .load      (last_bit),
        .load_data (next_word),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .accept    (accept),
        .drop      (drop)
    );

    // Statistics: clr takes priority over a same-cycle commit or drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
            ovf       <= 1'b0;
        end else if (clr) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
            ovf       <= 1'b0;
        end else begin
            if (accept) begin
                frame_cnt <= CNT_W'(sat_inc(32'(frame_cnt), CNT_MAX));
            end
            if (drop) begin
                drop_cnt <= CNT_W'(sat_inc(32'(drop_cnt), CNT_MAX));
                ovf      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_payload_capture.sv
// Bench for sync_payload_capture with PAYLOAD_W=8 and CNT_W=2: directed
// scenarios followed by random traffic, checked against a frame-level model.
module tb_sync_payload_capture;

    localparam int PW      = 8;
    localparam int CW      = 2;
    localparam int CNT_MAX = 3;

    logic          clk;
    logic          reset;
    logic          din;
    logic          det;
    logic          clr;
    logic [PW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] drop_cnt;
    logic          ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PW-1:0] exp_q[$];

    sync_payload_capture #(
        .PAYLOAD_W (PW),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .det       (det),
        .clr       (clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt),
        .ovf       (ovf)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish (got running, expected done)");
        $fatal(1, "timeout");
    end

    // ---------------- compare helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame-level view: collect bits after a sync pulse, assemble the word
    // arithmetically, and track whether the output slot is occupied.
    bit     m_in_frame;
    bit     m_bitq[$];
    bit     m_valid;
    int     m_frames;
    int     m_drops;
    bit     m_ovf;
    bit     m_popped;
    bit     m_accepted;
    bit     m_dropped;
    int     m_word;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_in_frame = 0;
            m_bitq.delete();
            m_valid  = 0;
            m_frames = 0;
            m_drops  = 0;
            m_ovf    = 0;
            exp_q.delete();
        end else begin
            m_popped   = m_valid && out_ready;
            m_accepted = 0;
            m_dropped  = 0;
            if (m_in_frame) begin
                m_bitq.push_back(din);
                if (m_bitq.size() == PW) begin
                    m_word = 0;
                    foreach (m_bitq[i]) m_word = m_word * 2 + int'(m_bitq[i]);
                    m_bitq.delete();
                    m_in_frame = 0;
                    if (!m_valid || out_ready) begin
                        exp_q.push_back(PW'(m_word));
                        m_accepted = 1;
                    end else begin
                        m_dropped = 1;
                    end
                end
            end else if (det) begin
                m_in_frame = 1;
            end
            if (m_accepted) m_valid = 1;
            else if (m_popped) m_valid = 0;
            if (m_popped && exp_q.size() > 0 && !(m_accepted && exp_q.size() == 1)) begin
                void'(exp_q.pop_front());
            end
            if (clr) begin
                m_frames = 0;
                m_drops  = 0;
                m_ovf    = 0;
            end else begin
                if (m_accepted && m_frames < CNT_MAX) m_frames++;
                if (m_dropped) begin
                    if (m_drops < CNT_MAX) m_drops++;
                    m_ovf = 1;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("busy", 32'(busy), 32'(m_in_frame));
        check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
        check("ovf", 32'(ovf), 32'(m_ovf));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_data_unexpected: got %0h expected no word at %0t", out_data, $time);
            end else begin
                check("out_data", 32'(out_data), 32'(exp_q[0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic d, input logic dt, input logic rdy, input logic c);
        din       = d;
        det       = dt;
        out_ready = rdy;
        clr       = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'($urandom_range(0, 1)), 1'b0, rdy, 1'b0);
    endtask

    // det cycle followed by PW payload bits; det_mask re-pulses det during SHIFT.
    task automatic send_frame(input logic [PW-1:0] w, input logic rdy_during,
                              input logic rdy_last, input logic clr_last,
                              input logic [PW-1:0] det_mask);
        drive(1'($urandom_range(0, 1)), 1'b1, rdy_during, 1'b0);
        for (int i = 0; i < PW; i++) begin
            drive(w[PW-1-i], det_mask[PW-1-i], (i == PW-1) ? rdy_last : rdy_during,
                  (i == PW-1) ? clr_last : 1'b0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;
        din = 1'b0; det = 1'b0; clr = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        reset = 1'b0;
        idle(6, 1'b1);

        // single frame 1,0,1,1,0,0,1,0
        send_frame(8'hB2, 1'b1, 1'b1, 1'b0, 8'h00);
        check("s1_valid", 32'(out_valid), 32'd1);
        check("s1_data", 32'(out_data), 32'hB2);
        check("s1_frame_cnt", 32'(frame_cnt), 32'd1);
        idle(1, 1'b1);
        check("s1_valid_one_cycle", 32'(out_valid), 32'd0);
        idle(3, 1'b1);

        // sync pulses inside the payload are ignored
        send_frame(8'h5C, 1'b1, 1'b1, 1'b0, 8'b0010_0100);
        check("s2_data", 32'(out_data), 32'h5C);
        idle(12, 1'b1);

        // back-pressure: first word held, second dropped
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 8'h00);
        check("s3_held", 32'(out_data), 32'hA5);
        check("s3_drop_cnt", 32'(drop_cnt), 32'd1);
        check("s3_ovf", 32'(ovf), 32'd1);
        idle(1, 1'b1);
        check("s3_consumed", 32'(out_valid), 32'd0);
        idle(2, 1'b1);

        // pop and commit on the same edge
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 8'h00);
        send_frame(8'h7E, 1'b0, 1'b1, 1'b0, 8'h00);
        check("s4_valid", 32'(out_valid), 32'd1);
        check("s4_data", 32'(out_data), 32'h7E);
        check("s4_drop_cnt", 32'(drop_cnt), 32'd0);
        idle(2, 1'b1);

        // reset mid-shift after 4 bits
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        idle(2, 1'b1);
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_valid", 32'(out_valid), 32'd0);
        check("s5_frame_cnt", 32'(frame_cnt), 32'd0);
        reset = 1'b0;
        idle(2, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b1, 1'b0, 8'h00);
        check("s5_data", 32'(out_data), 32'hC3);
        check("s5_frame_cnt_after", 32'(frame_cnt), 32'd1);
        idle(2, 1'b1);

        // saturation, then clr coinciding with a commit
        for (int f = 0; f < 5; f++) send_frame(8'($urandom), 1'b1, 1'b1, 1'b0, 8'h00);
        check("s6_frame_sat", 32'(frame_cnt), 32'd3);
        idle(2, 1'b1);
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 8'h00);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 8'h00);
        check("s6_ovf_set", 32'(ovf), 32'd1);
        send_frame(8'h33, 1'b0, 1'b1, 1'b1, 8'h00);
        check("s6_clr_frame", 32'(frame_cnt), 32'd0);
        check("s6_clr_drop", 32'(drop_cnt), 32'd0);
        check("s6_clr_ovf", 32'(ovf), 32'd0);
        check("s6_clr_word", 32'(out_data), 32'h33);
        idle(2, 1'b1);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));
        end
        idle(12, 1'b1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
